// File: rtl/lcd_line_streamer_pkg.sv
// Shared LCD streaming definitions: frame geometry defaults and the line streamer state set.
// Also used by the line RAM and the upstream line filler.
package lcd_pkg;

  localparam int DEF_DATA_WDTH = 8;
  localparam int DEF_COL       = 480;
  localparam int DEF_COL_BITS  = 9;
  localparam int DEF_ROWS      = 320;
  localparam int DEF_ROW_BITS  = 9;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_FILL,
    STREAM,
    DONE
  } lcd_state_e;

endpackage

// File: rtl/lcd_line_streamer_if.sv
// Line-RAM read port, upstream fill handshake and downstream byte stream of the LCD line streamer.
interface lcd_line_streamer_if import lcd_pkg::*; #(
  parameter int DATA_WDTH = DEF_DATA_WDTH,
  parameter int COL_BITS  = DEF_COL_BITS,
  parameter int ROW_BITS  = DEF_ROW_BITS
);

  logic                 line_req;
  logic                 line_ready;
  logic [ROW_BITS-1:0]  row_idx;
  logic [COL_BITS-1:0]  addrb;
  logic [DATA_WDTH-1:0] doutb;
  logic [DATA_WDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output line_req, row_idx, addrb, m_data, m_valid,
    input  line_ready, doutb, m_ready
  );

  modport slave (
    input  line_req, row_idx, addrb, m_data, m_valid,
    output line_ready, doutb, m_ready
  );

endinterface

// File: rtl/lcd_line_streamer_skid_buf2.sv
// Two-entry valid/ready byte buffer; the writer must only push when an entry is guaranteed free.
module lcd_skid_buf2 import lcd_pkg::*; #(
  parameter int DATA_WDTH = DEF_DATA_WDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_WDTH-1:0] in_data,
  output logic                 out_valid,
  output logic [DATA_WDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic [1:0]           count
);

  logic [DATA_WDTH-1:0] slot0;
  logic [DATA_WDTH-1:0] slot1;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic                 pop;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = rd_ptr ? slot1 : slot0;

  // Head entry is never overwritten while it is presented, so a stalled byte stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (in_valid) begin
        if (wr_ptr) slot1 <= in_data;
        else        slot0 <= in_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, in_valid} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/lcd_line_streamer.sv
// Streams a frame of ROWS lines out of the line RAM as bytes, requesting each line refill
// from the upstream filler and pulsing frame_done after the last byte of the last row.
module lcd_line_streamer import lcd_pkg::*; #(
  parameter int DATA_WDTH = DEF_DATA_WDTH,
  parameter int COL       = DEF_COL,
  parameter int COL_BITS  = DEF_COL_BITS,
  parameter int ROWS      = DEF_ROWS,
  parameter int ROW_BITS  = DEF_ROW_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  lcd_line_streamer_if.master  bus
);

  localparam logic [COL_BITS:0]   COL_N    = (COL_BITS+1)'(COL);
  localparam logic [COL_BITS:0]   LAST_COL = (COL_BITS+1)'(COL-1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS-1);

  lcd_state_e           state;
  lcd_state_e           state_nxt;
  logic [ROW_BITS-1:0]  row_idx;
  logic [COL_BITS-1:0]  addr_q;
  logic [COL_BITS:0]    issue_cnt;
  logic [COL_BITS:0]    accept_cnt;
  logic                 in_flight;
  logic                 issue;
  logic                 pop;
  logic                 line_last;
  logic [1:0]           buf_count;
  logic                 buf_valid;
  logic [DATA_WDTH-1:0] buf_data;
  logic [2:0]           occupancy;

  lcd_skid_buf2 #(.DATA_WDTH(DATA_WDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_flight),
    .in_data   (bus.doutb),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .out_ready (bus.m_ready),
    .count     (buf_count)
  );

  // Occupancy counts the byte leaving this cycle as already gone, which keeps one read
  // in flight per cycle with m_ready high while never exceeding the two buffer entries.
  assign pop       = buf_valid && bus.m_ready;
  assign occupancy = {1'b0, buf_count} + {2'b00, in_flight} - {2'b00, pop};
  assign issue     = (state == STREAM) && (issue_cnt < COL_N) && (occupancy < 3'd2);
  assign line_last = pop && (accept_cnt == LAST_COL);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = REQ;
      REQ:       state_nxt = WAIT_FILL;
      WAIT_FILL: if (bus.line_ready) state_nxt = STREAM;
      STREAM:    if (line_last) state_nxt = (row_idx == LAST_ROW) ? DONE : REQ;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Column counters restart at each line end so the next row reads from address 0 again;
  // addr_q stops at COL-1 rather than running one past the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx    <= '0;
      addr_q     <= '0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
      in_flight  <= 1'b0;
    end else begin
      in_flight <= issue;
      if (state == IDLE && start) row_idx <= '0;
      if (line_last) begin
        if (row_idx != LAST_ROW) row_idx <= row_idx + ROW_BITS'(1);
        addr_q     <= '0;
        issue_cnt  <= '0;
        accept_cnt <= '0;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + (COL_BITS+1)'(1);
          if (issue_cnt != LAST_COL) addr_q <= addr_q + COL_BITS'(1);
        end
        if (pop) accept_cnt <= accept_cnt + (COL_BITS+1)'(1);
      end
    end
  end

  assign busy         = (state != IDLE);
  assign frame_done   = (state == DONE);
  assign bus.line_req = (state == REQ);
  assign bus.row_idx  = row_idx;
  assign bus.addrb    = addr_q;
  assign bus.m_data   = buf_data;
  assign bus.m_valid  = buf_valid;

endmodule

// File: tb/tb_lcd_line_streamer.sv
// Directed bench: small 4x2 frame with stalls/reset, plus a 480-wide frame and a 1x1 frame.
module tb_lcd_line_streamer;
  import lcd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic rst_n_s, start_s, busy_s, done_s_o;
  logic rst_b, start_b, busy_b, done_b_o, busy_t, done_t_o;

  lcd_line_streamer_if #(.DATA_WDTH(8), .COL_BITS(2), .ROW_BITS(1)) bus_s ();
  lcd_line_streamer_if #(.DATA_WDTH(8), .COL_BITS(9), .ROW_BITS(9)) bus_b ();
  lcd_line_streamer_if #(.DATA_WDTH(8), .COL_BITS(1), .ROW_BITS(1)) bus_t ();

  lcd_line_streamer #(.DATA_WDTH(8), .COL(4), .COL_BITS(2), .ROWS(2), .ROW_BITS(1)) dut_s (
    .clk(clk), .rst_n(rst_n_s), .start(start_s), .busy(busy_s), .frame_done(done_s_o), .bus(bus_s));
  lcd_line_streamer #(.DATA_WDTH(8), .COL(480), .COL_BITS(9), .ROWS(4), .ROW_BITS(9)) dut_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .busy(busy_b), .frame_done(done_b_o), .bus(bus_b));
  lcd_line_streamer #(.DATA_WDTH(8), .COL(1), .COL_BITS(1), .ROWS(1), .ROW_BITS(1)) dut_t (
    .clk(clk), .rst_n(rst_b), .start(start_b), .busy(busy_t), .frame_done(done_t_o), .bus(bus_t));

  // Line RAM read ports, one cycle of latency
  logic [7:0] ram_s [4];
  always @(posedge clk) bus_s.doutb <= ram_s[bus_s.addrb];
  always @(posedge clk) bus_b.doutb <= 8'(bus_b.addrb) ^ 8'h5A;
  always @(posedge clk) bus_t.doutb <= 8'hA5;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic toggle_mode = 1'b0;
  initial begin
    bit pat [6];
    int k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    k = 0;
    bus_s.m_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (toggle_mode) begin
        bus_s.m_ready = pat[k];
        k = (k + 1) % 6;
      end else begin
        bus_s.m_ready = 1'b1;
      end
    end
  end

  // Small-instance monitor: records accepted bytes and checks stall stability
  logic [7:0] got_q [$];
  int         cyc_q [$];
  int         cyc = 0;
  int         done_s = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n_s) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_output("stall valid", bus_s.m_valid, 1);
        check_output("stall data", bus_s.m_data, held);
      end
      stall_prev = bus_s.m_valid && !bus_s.m_ready;
      held = bus_s.m_data;
      if (bus_s.m_valid && bus_s.m_ready) begin
        got_q.push_back(bus_s.m_data);
        cyc_q.push_back(cyc);
      end
      if (done_s_o) done_s++;
    end
  end

  int cnt_b = 0, done_b = 0, max_b = 0, cnt_t = 0, done_t = 0, max_t = 0;
  always @(negedge clk) begin
    if (rst_b) begin
      if (int'(bus_b.addrb) > max_b) max_b = int'(bus_b.addrb);
      if (int'(bus_t.addrb) > max_t) max_t = int'(bus_t.addrb);
      if (bus_b.m_valid && bus_b.m_ready) begin
        check_output("big byte", bus_b.m_data, 8'(cnt_b % 480) ^ 8'h5A);
        cnt_b++;
      end
      if (bus_t.m_valid && bus_t.m_ready) begin
        check_output("tiny byte", bus_t.m_data, 8'hA5);
        cnt_t++;
      end
      if (done_b_o) done_b++;
      if (done_t_o) done_t++;
    end
  end

  task automatic serve_line(input string tag, input logic [31:0] exp_row, input int hold);
    int n;
    logic [1:0] addr0;
    logic valid_seen, addr_moved, busy_low;
    n = 0;
    while (bus_s.line_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, " line_req"}, bus_s.line_req, 1);
    check_output({tag, " row_idx"}, bus_s.row_idx, exp_row);
    @(negedge clk);
    addr0 = bus_s.addrb;
    valid_seen = 1'b0; addr_moved = 1'b0; busy_low = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus_s.m_valid !== 1'b0) valid_seen = 1'b1;
      if (bus_s.addrb !== addr0) addr_moved = 1'b1;
      if (busy_s !== 1'b1) busy_low = 1'b1;
    end
    if (hold > 0) begin
      check_output({tag, " withheld m_valid"}, valid_seen, 0);
      check_output({tag, " withheld addrb"}, addr_moved, 0);
      check_output({tag, " withheld busy"}, busy_low, 0);
    end
    bus_s.line_ready = 1'b1;
    @(negedge clk);
    bus_s.line_ready = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (done_s_o !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, " frame_done"}, done_s_o, 1);
    @(negedge clk);
    check_output({tag, " busy after"}, busy_s, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_seq(input string tag);
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_output({tag, " byte count"}, got_q.size(), 8);
    for (int i = 0; i < got_q.size() && i < 8; i++)
      check_output({tag, " byte"}, got_q[i], exp_b[i % 4]);
  endtask

  task automatic pulse_start;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
  endtask

  initial begin
    int n;
    ram_s = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_n_s = 1'b0; rst_b = 1'b0; start_s = 1'b0; start_b = 1'b0;
    bus_s.line_ready = 1'b0;
    bus_b.line_ready = 1'b1; bus_b.m_ready = 1'b1;
    bus_t.line_ready = 1'b1; bus_t.m_ready = 1'b1;
    #3;
    check_output("rst busy", busy_s, 0);
    check_output("rst line_req", bus_s.line_req, 0);
    check_output("rst m_valid", bus_s.m_valid, 0);
    check_output("rst frame_done", done_s_o, 0);
    check_output("rst row_idx", bus_s.row_idx, 0);
    check_output("rst addrb", bus_s.addrb, 0);
    check_output("rst m_data", bus_s.m_data, 0);
    @(negedge clk);
    rst_n_s = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;

    $display("[TB] frame 1: m_ready held high");
    pulse_start();
    check_output("f1 busy", busy_s, 1);
    serve_line("f1 r0", 0, 0);
    serve_line("f1 r1", 1, 0);
    wait_frame("f1");
    check_seq("f1");
    for (int i = 1; i < cyc_q.size(); i++)
      if (i % 4 != 0) check_output("f1 back-to-back", cyc_q[i] - cyc_q[i-1], 1);
    check_output("f1 done count", done_s, 1);
    got_q.delete(); cyc_q.delete();

    $display("[TB] frame 2: m_ready pattern, stray start/line_ready, late fill");
    toggle_mode = 1'b1;
    pulse_start();
    serve_line("f2 r0", 0, 0);
    repeat (3) @(negedge clk);
    start_s = 1'b1; bus_s.line_ready = 1'b1;
    @(negedge clk);
    start_s = 1'b0; bus_s.line_ready = 1'b0;
    serve_line("f2 r1", 1, 50);
    wait_frame("f2");
    check_seq("f2");
    check_output("f2 done count", done_s, 2);
    toggle_mode = 1'b0;
    got_q.delete(); cyc_q.delete();

    $display("[TB] frame 3: reset mid-row");
    pulse_start();
    serve_line("f3 r0", 0, 0);
    n = 0;
    while (got_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("f3 two bytes", got_q.size() >= 2, 1);
    @(posedge clk);
    #2 rst_n_s = 1'b0;
    #1;
    check_output("mid rst busy", busy_s, 0);
    check_output("mid rst m_valid", bus_s.m_valid, 0);
    check_output("mid rst m_data", bus_s.m_data, 0);
    check_output("mid rst addrb", bus_s.addrb, 0);
    check_output("mid rst line_req", bus_s.line_req, 0);
    check_output("mid rst frame_done", done_s_o, 0);
    @(negedge clk);
    rst_n_s = 1'b1;
    got_q.delete(); cyc_q.delete();
    @(negedge clk);
    pulse_start();
    serve_line("f4 r0", 0, 0);
    serve_line("f4 r1", 1, 0);
    wait_frame("f4");
    check_seq("f4");
    check_output("f4 done count", done_s, 3);

    n = 0;
    while (done_b < 1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check_output("big byte count", cnt_b, 1920);
    check_output("big done count", done_b, 1);
    check_output("big addrb max", max_b, 479);
    check_output("big busy after", busy_b, 0);
    check_output("tiny byte count", cnt_t, 1);
    check_output("tiny done count", done_t, 1);
    check_output("tiny addrb max", max_t, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
